alu_pipe: RTL and testbench

//  Registered, handshaked successor of the combinational execute ALU, parametrised in datapath width.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_iter_mul.sv | 59 +++++
 rtl/alu_pipe.sv | 113 +++++++++++
 tb/tb_alu_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the pipelined execute ALU.
package alu_pkg;

    // ALUCtrl_i opcode encodings (independent of datapath width)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;  // SRL when sub_srl_i = 1
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    // Handshake FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles total.
// product_o/done_o are valid combinationally in the final iteration cycle.
module alu_iter_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             run;

    // Accumulate the current partial product; exposes the finished sum on the last step
    always_comb begin
        acc_next  = acc + (mplier[0] ? mcand : '0);
        done_o    = run && (cnt == LAST);
        product_o = acc_next;
    end

    // Operand latch on start, then one shift-add step per cycle until the count runs out
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start_i) begin
            mcand  <= a_i;
            mplier <= b_i;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == LAST) begin
                cnt <= '0;
                run <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered, valid/ready handshaked execute ALU. Single-cycle ops finish in one
// cycle; MUL occupies the block for WIDTH cycles via the iterative multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic             sub_srl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             busy_o
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_t       state;
    logic             accept;
    logic             is_mul;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;

    // Handshake: ready while idle, or while presenting a result that is being consumed
    always_comb begin
        ready_o = (state == ST_IDLE) || ((state == ST_DONE) && ready_i);
        accept  = valid_i && ready_o;
        is_mul  = (ALUCtrl_i == ALU_MUL);
        busy_o  = (state == ST_MUL);
        shamt   = data2_i[SHW-1:0];
    end

    // Single-cycle result mux; MUL result comes from the iterative unit instead
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            ALU_ADD: alu_res = data1_i + data2_i;
            ALU_SLL: alu_res = data1_i << shamt;
            ALU_SUB: alu_res = data1_i - data2_i;
            ALU_MUL: alu_res = '0;
            ALU_XOR: alu_res = data1_i ^ data2_i;
            ALU_SRA: alu_res = sub_srl_i ? (data1_i >> shamt)
                                         : WIDTH'($signed(data1_i) >>> shamt);
            ALU_OR:  alu_res = data1_i | data2_i;
            ALU_AND: alu_res = data1_i & data2_i;
            default: alu_res = '0;
        endcase
    end

    alu_iter_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (accept && is_mul),
        .a_i      (data1_i),
        .b_i      (data2_i),
        .done_o   (mul_done),
        .product_o(mul_res)
    );

    // Control FSM with registered result, valid and zero flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
            data_o  <= '0;
            zero_o  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // accept already implies ready_i when in DONE
                    if (accept) begin
                        if (is_mul) begin
                            state   <= ST_MUL;
                            valid_o <= 1'b0;
                        end else begin
                            state   <= ST_DONE;
                            valid_o <= 1'b1;
                            data_o  <= alu_res;
                            zero_o  <= (alu_res == '0);
                        end
                    end else if ((state == ST_DONE) && ready_i) begin
                        state   <= ST_IDLE;
                        valid_o <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state   <= ST_DONE;
                        valid_o <= 1'b1;
                        data_o  <= mul_res;
                        zero_o  <= (mul_res == '0);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: vector table, hand-written multi-cycle
// sequences, and a randomized run against a transaction-level reference model.
module tb_alu_pipe;

    logic        clk;
    logic        rst;
    logic        valid_i, ready_i, sub_srl;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        ready_o, valid_o, zero_o, busy_o;
    logic [31:0] data_o;

    logic        valid8, ready8, srl8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, data8;
    logic        ready8_o, valid8_o, zero8_o, busy8_o;

    int n_cmp = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .data1_i(a), .data2_i(b), .ALUCtrl_i(op), .sub_srl_i(sub_srl),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .zero_o(zero_o), .busy_o(busy_o)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid8), .ready_o(ready8_o),
        .data1_i(a8), .data2_i(b8), .ALUCtrl_i(op8), .sub_srl_i(srl8),
        .valid_o(valid8_o), .ready_i(ready8), .data_o(data8),
        .zero_o(zero8_o), .busy_o(busy8_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU from the opcode definitions, plain wide arithmetic
    function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic s,
                                            input logic [31:0] x, input logic [31:0] y);
        int unsigned n;
        logic [63:0] wide;
        n = y % 32;
        case (o)
            3'd0: return x + y;
            3'd1: return x << n;
            3'd2: return x - y;
            3'd3: begin wide = {32'b0, x} * {32'b0, y}; return wide[31:0]; end
            3'd4: return x ^ y;
            3'd5: begin
                if (s) return x >> n;
                wide = {{32{x[31]}}, x} >> n;
                return wide[31:0];
            end
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        srl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int busy_cnt, k_valid;
        bit rdy_bad, saw_valid, pred_ready, acc_m;
        bit m_valid;
        int m_wait;
        logic [31:0] m_data, m_mulres;

        vecs[0]  = '{"add",     3'd0, 1'b0, 32'd5,         32'd7,         32'h0000_000C};
        vecs[1]  = '{"sub",     3'd2, 1'b0, 32'd3,         32'd5,         32'hFFFF_FFFE};
        vecs[2]  = '{"xor",     3'd4, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F};
        vecs[3]  = '{"sra",     3'd5, 1'b0, 32'h8000_0000, 32'd4,         32'hF800_0000};
        vecs[4]  = '{"srl",     3'd5, 1'b1, 32'h8000_0000, 32'd4,         32'h0800_0000};
        vecs[5]  = '{"sll33",   3'd1, 1'b0, 32'h0000_0001, 32'd33,        32'h0000_0002};
        vecs[6]  = '{"or",      3'd6, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
        vecs[7]  = '{"and_srl", 3'd7, 1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00};
        vecs[8]  = '{"addwrap", 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
        vecs[9]  = '{"sra_pos", 3'd5, 1'b0, 32'h7FFF_FFF0, 32'hFFFF_FFE4, 32'h07FF_FFFF};
        vecs[10] = '{"subwrap", 3'd2, 1'b0, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF};
        vecs[11] = '{"sll_sub", 3'd1, 1'b1, 32'h8000_0001, 32'd1,         32'h0000_0002};

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; sub_srl = 1'b0;
        op = 3'd0; a = '0; b = '0;
        valid8 = 1'b0; ready8 = 1'b1; srl8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;

        // Reset state
        #3;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data",  data_o,       32'd0);
        check("rst_zero",  32'(zero_o),  32'd1);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_busy",  32'(busy_o),  32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back single-cycle vectors with ready_i held high
        foreach (vecs[i]) begin
            valid_i = 1'b1; op = vecs[i].op; sub_srl = vecs[i].srl;
            a = vecs[i].a; b = vecs[i].b;
            #1;
            check({vecs[i].name, "_ready"}, 32'(ready_o), 32'd1);
            tick();
            check({vecs[i].name, "_valid"}, 32'(valid_o), 32'd1);
            check(vecs[i].name, data_o, vecs[i].exp);
            check({vecs[i].name, "_zero"}, 32'(zero_o), 32'(vecs[i].exp == 32'd0));
        end
        valid_i = 1'b0;
        tick();
        check("drain_valid", 32'(valid_o), 32'd0);

        // MUL at WIDTH=32, operands scrambled after accept
        valid_i = 1'b1; op = 3'd3; sub_srl = 1'b0; a = 32'h0001_0000; b = 32'h0001_0001;
        tick();
        valid_i = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        busy_cnt = 0; k_valid = 0; rdy_bad = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (valid_o) begin k_valid = k; break; end
            if (busy_o) busy_cnt++;
            if (ready_o) rdy_bad = 1'b1;
            valid_i = 1'b1; op = 3'd0;
            tick();
            valid_i = 1'b0;
        end
        check("mul_latency", 32'(k_valid), 32'd33);
        check("mul_busy_cycles", 32'(busy_cnt), 32'd32);
        check("mul_ready_low", 32'(rdy_bad), 32'd0);
        check("mul_result", data_o, 32'h0001_0000);
        check("mul_busy_after", 32'(busy_o), 32'd0);
        tick();
        check("mul_drain", 32'(valid_o), 32'd0);

        // Backpressure on a zero result
        ready_i = 1'b0; valid_i = 1'b1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd1;
        tick();
        check("bp_valid", 32'(valid_o), 32'd1);
        a = 32'd1; b = 32'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready", 32'(ready_o), 32'd0);
            tick();
            check("bp_data", data_o, 32'd0);
            check("bp_zero", 32'(zero_o), 32'd1);
            check("bp_hold", 32'(valid_o), 32'd1);
        end
        ready_i = 1'b1; valid_i = 1'b0;
        tick();
        check("bp_release", 32'(valid_o), 32'd0);
        check("bp_idle_ready", 32'(ready_o), 32'd1);

        // Asynchronous reset mid-cycle while holding a result
        ready_i = 1'b0; valid_i = 1'b1; a = 32'd3; b = 32'd4;
        tick();
        valid_i = 1'b0;
        check("hold_data", data_o, 32'd7);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_data",  data_o,       32'd0);
        check("arst_zero",  32'(zero_o),  32'd1);
        check("arst_ready", 32'(ready_o), 32'd1);
        #2 rst = 1'b0;
        ready_i = 1'b1;
        tick();
        check("arst_no_pulse", 32'(valid_o), 32'd0);

        // Reset during MUL at count 10, then a fresh ADD
        valid_i = 1'b1; op = 3'd3; a = 32'd9; b = 32'd9;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mul10_busy", 32'(busy_o), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("mulrst_busy", 32'(busy_o), 32'd0);
        check("mulrst_ready", 32'(ready_o), 32'd1);
        #2 rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_o) saw_valid = 1'b1;
        end
        check("mulrst_no_valid", 32'(saw_valid), 32'd0);
        valid_i = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
        tick();
        valid_i = 1'b0;
        check("post_rst_valid", 32'(valid_o), 32'd1);
        check("post_rst_add", data_o, 32'd2);
        tick();

        // MUL at WIDTH=8
        valid8 = 1'b1; op8 = 3'd3; a8 = 8'h10; b8 = 8'h11;
        tick();
        valid8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        busy_cnt = 0; k_valid = 0;
        for (int k = 1; k <= 30; k++) begin
            if (valid8_o) begin k_valid = k; break; end
            if (busy8_o) busy_cnt++;
            tick();
        end
        check("mul8_latency", 32'(k_valid), 32'd9);
        check("mul8_busy_cycles", 32'(busy_cnt), 32'd8);
        check("mul8_result", 32'(data8), 32'h10);
        check("mul8_zero", 32'(zero8_o), 32'd0);

        // Randomized run against the transaction-level model
        m_valid = 1'b0; m_wait = 0; m_data = '0; m_mulres = '0;
        for (int it = 0; it < 400; it++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            if (op == 3'd3 && $urandom_range(0, 3) != 0) op = 3'd0;
            sub_srl = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 70)) : $urandom;
            #1;
            pred_ready = (m_wait == 0) && (!m_valid || ready_i);
            check("rnd_ready", 32'(ready_o), 32'(pred_ready));
            acc_m = valid_i && pred_ready;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1'b1;
                    m_data  = m_mulres;
                end
            end else begin
                if (m_valid && ready_i) m_valid = 1'b0;
                if (acc_m) begin
                    if (op == 3'd3) begin
                        m_wait   = 32;
                        m_mulres = ref_alu(op, sub_srl, a, b);
                        m_valid  = 1'b0;
                    end else begin
                        m_valid = 1'b1;
                        m_data  = ref_alu(op, sub_srl, a, b);
                    end
                end
            end
            tick();
            check("rnd_valid", 32'(valid_o), 32'(m_valid));
            check("rnd_busy", 32'(busy_o), 32'(m_wait > 0));
            if (m_valid) begin
                check("rnd_data", data_o, m_data);
                check("rnd_zero", 32'(zero_o), 32'(m_data == 32'd0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
